// File: rtl/ctrl_useq_if.sv
// ctrl_useq_if: microcode ROM bus between sequencer (master) and async ROM (slave)
// uaddr: ROM address {opcode, step}; uword: {cond_en, cond_idx[1:0], halt, end, con}
interface ctrl_useq_if #(
  parameter int OPW = 8,
  parameter int SW  = 3,
  parameter int CW  = 30
);
  logic [OPW+SW-1:0] uaddr;
  logic [CW+4:0]     uword;
  modport master (output uaddr, input uword);
  modport slave  (input uaddr, output uword);
endinterface

// File: rtl/ctrl_useq.sv
// ctrl_useq: microsequencer running a fixed 3-state fetch then stepping an async microcode ROM
// clk, clr_n (async active-low): clock and reset
// run, step, wt: free-run / single-step request / wait-stall
// i, flags: opcode from IR and {xz,xm,az,am}
// rom: ROM bus (uaddr out, uword in)
// con, hlt, tstate, done: control word, halted, current T number, end-of-instruction pulse
module ctrl_useq #(
  parameter int OPW = 8,
  parameter int CW = 30,
  parameter int FLAGW = 4,
  parameter int MAXEX = 6,
  parameter int SW = 3,
  parameter logic [CW-1:0] FETCH1 = 30'h0000003,
  parameter logic [CW-1:0] FETCH2 = 30'h0000004,
  parameter logic [CW-1:0] FETCH3 = 30'h0000018
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             run,
  input  logic             step,
  input  logic             wt,
  input  logic [OPW-1:0]   i,
  input  logic [FLAGW-1:0] flags,
  ctrl_useq_if.master      rom,
  output logic [CW-1:0]    con,
  output logic             hlt,
  output logic [SW+1:0]    tstate,
  output logic             done
);
  typedef enum logic [2:0] {F1, F2, F3, EX, IDLE, HALT} state_t;
  state_t st;
  logic [SW-1:0] cnt;
  logic step_q;
  logic [CW-1:0] ucon;
  logic uend, uhalt, cen, cfail, halt_go, last, hold, step_rise;
  logic [1:0] cidx;
  assign ucon = rom.uword[CW-1:0];
  assign uend = rom.uword[CW];
  assign uhalt = rom.uword[CW+1];
  assign cidx = rom.uword[CW+3:CW+2];
  assign cen = rom.uword[CW+4];
  assign cfail = cen & ~flags[cidx];
  assign halt_go = uhalt & ~cfail;
  assign last = uend | uhalt | cfail | (cnt == SW'(MAXEX-1));
  // wait only freezes the active instruction; IDLE and HALT ignore it
  assign hold = wt & (st != IDLE) & (st != HALT);
  assign step_rise = step & ~step_q;
  assign done = (st == EX) & last & ~halt_go & ~wt;
  assign rom.uaddr = {i, (st == EX) ? cnt : SW'(0)};
  always_comb begin
    con = (st == F1) ? FETCH1 :
          (st == F2) ? FETCH2 :
          (st == F3) ? FETCH3 :
          (st == EX && !cfail) ? ucon : '0;
    tstate = (st == F1) ? (SW+2)'(1) :
             (st == F2) ? (SW+2)'(2) :
             (st == F3) ? (SW+2)'(3) :
             (st == EX) ? (SW+2)'(cnt) + (SW+2)'(4) : '0;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st <= F1;
      cnt <= '0;
      hlt <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= step;
      if (!hold) begin
        case (st)
          F1: st <= F2;
          F2: st <= F3;
          F3: begin
            st <= EX;
            cnt <= '0;
          end
          EX: begin
            cnt <= last ? '0 : cnt + 1'b1;
            st <= !last ? EX : halt_go ? HALT : run ? F1 : IDLE;
            hlt <= last & halt_go;
          end
          IDLE: st <= (run | step_rise) ? F1 : IDLE;
          HALT: st <= HALT;
          default: st <= F1;
        endcase
      end
    end
  end
endmodule
